sram_bus_arbiter: RTL and testbench
===================================

# sram_bus_arbiter

- Sits directly downstream of the CPU core's two memory ports (fetch and data) and multiplexes them onto one asynchronous external SRAM.
- Generates `ibus_stall_req` and `mem_stall_req` back to the core.
- Data port has fixed priority over instruction fetch.
- Optionally hosts the machine timer (`mtime`/`mtimecmp`), which drives the core's `time_int` and `clear_mip` inputs.

## Interface
Parameters:
- `WAIT_CYCLES`, default 3: cycles an SRAM access is held in ACCESS; legal range 2..15.
- `MTIME_ADDR`, default 32'h0200_BFF8: byte address of `mtime` low word; high word at +4.
- `MTIMECMP_ADDR`, default 32'h0200_4000: byte address of `mtimecmp` low word; high word at +4.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_address`  in  32  fetch byte address.
- `if_load`  in  1  fetch request.
- `if_rdata`  out  32  fetched word.
- `ibus_stall_req`  out  1  fetch not yet complete.
- `mem_address`  in  32  data byte address.
- `mem_load`  in  1  data read request.
- `mem_store`  in  1  data write request.
- `mem_wdata`  in  32  store data.
- `mem_byte_en`  in  4  store byte lanes.
- `mem_rdata`  out  32  load data.
- `mem_stall_req`  out  1  data access not yet complete.
- `time_int`  out  1  timer interrupt level.
- `clear_mip`  out  1  one-cycle pulse on a `mtimecmp` write.
- `sram_addr`  out  20  word address, equal to byte address[21:2].
- `sram_wdata`  out  32  write data.
- `sram_rdata`  in  32  read data.
- `sram_ce_n`  out  1  chip enable, active-low.
- `sram_oe_n`  out  1  output enable, active-low.
- `sram_we_n`  out  1  write enable, active-low.
- `sram_be_n`  out  4  byte enables, active-low.

## Operation
State machine: IDLE, ACCESS, DONE. Registers: `owner` (INST/DATA), `is_write`, `cnt` (4 bits), `rdata_q` (32 bits).

- **IDLE:**
  - If `mem_load | mem_store`: grant DATA.
  - Else if `if_load`: grant INST.
  - Else: remain in IDLE.
- **Grant (IDLE -> ACCESS):** register `sram_addr`, `sram_wdata` and `sram_be_n`. Reads use `sram_be_n` = 4'b0000. Stores use `sram_be_n` = ~`mem_byte_en`. Clear `cnt`.
- **ACCESS:**
  - `sram_ce_n` = 0 throughout.
  - Reads: `sram_oe_n` = 0 throughout.
  - Writes: `sram_we_n` = 0 for `cnt` < WAIT_CYCLES-1, and 1 on the final cycle (hold time).
  - `cnt` increments each cycle.
  - On the edge ending the cycle with `cnt` == WAIT_CYCLES-1: capture `sram_rdata` into `rdata_q`, then go to DONE.
- **DONE:**
  - All strobes deasserted.
  - Owner's stall request is low, and `if_rdata`/`mem_rdata` = `rdata_q`.
  - Next state is unconditionally IDLE.
- **Stall rule (combinational):**
  - `mem_stall_req` = (`mem_load|mem_store`) & !(state==DONE & owner==DATA).
  - `ibus_stall_req` = `if_load` & !(state==DONE & owner==INST).
  - The core holds request inputs stable while its stall is high. The arbiter does not re-check them mid-access.
- **Simultaneous requests:** data is served first. Fetch stays stalled and is served on the next IDLE.
- **Write ordering:** a store followed by a load to the same address returns the stored value. There is no write buffer.

## Timing
- Read request seen in IDLE at cycle 0 -> ACCESS in cycles 1..WAIT_CYCLES -> DONE at cycle WAIT_CYCLES+1, with stall low. Back-to-back accesses have a throughput of WAIT_CYCLES+2 cycles.
- Timer access: IDLE -> DONE directly, so stall is low at cycle 1 and SRAM strobes stay high.
- Reset values (asynchronous, mid-access included):
  - state IDLE.
  - `sram_ce_n`/`sram_oe_n`/`sram_we_n` = 1.
  - `sram_be_n` = 4'hF.
  - `sram_addr` = 0, `sram_wdata` = 0, `rdata_q` = 0.
  - `time_int` = 0, `clear_mip` = 0.
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
- Because `rdata_q` resets to 0, `if_rdata` and `mem_rdata` read 0 after reset.
- A write aborted by reset leaves SRAM contents undefined. No retry is performed.

## Configuration
Macro `SRAM_ARB_MTIMER_EN`.

Defined:
- `mtime` is a 64-bit counter, +1 every cycle.
- Data accesses to the four timer word addresses hit the timer registers. Stores honour `mem_byte_en`.
- A store to `mtime` overrides that cycle's increment.
- `time_int` is registered: (`mtime` >= `mtimecmp`, unsigned).
- `clear_mip` pulses high for exactly one cycle after any `mtimecmp` store.
- Fetches to timer addresses go to SRAM.

Undefined:
- No timer registers exist.
- `time_int` = 0 and `clear_mip` = 0 constantly.
- All data addresses go to SRAM.

## Test plan
- **Read latency:** preload SRAM word 0x10 = 32'hDEADBEEF; `if_load`=1 with `if_address`=0x40 at cycle 0 -> `ibus_stall_req` is high for cycles 0..3, `if_rdata`=32'hDEADBEEF at cycle 4, with WAIT_CYCLES=3.
- **Arbitration:** `if_load` and `mem_load` both asserted in cycle 0 -> data served first (`mem_stall_req` low at cycle 4), fetch completes at cycle 9.
- **Byte store:** `mem_store` to 0x100 with `mem_byte_en`=4'b0010 and `mem_wdata`=32'h0000AB00 over old word 32'h11223344 -> `sram_be_n`=4'b1101, and a reload returns 32'h1122AB44.
- **Timer (macro on):** write `mtimecmp` low = 50, high = 0 -> `clear_mip` pulses once per store; `time_int` rises exactly when `mtime` reaches 50; a timer load completes with 1 stall cycle.
- **Reset mid-write:** assert `rst`=0 while in ACCESS with `sram_we_n`=0 -> all strobes go high in the same cycle, state is IDLE, both stall requests follow their request inputs.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the core's fetch and data ports onto one asynchronous SRAM; data has priority.
// Define SRAM_ARB_MTIMER_EN to map the mtime/mtimecmp machine timer into the data port.
module sram_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES   = 3,
    parameter logic [31:0] MTIME_ADDR    = 32'h0200_BFF8,
    parameter logic [31:0] MTIMECMP_ADDR = 32'h0200_4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_address,
    input  logic        if_load,
    output logic [31:0] if_rdata,
    output logic        ibus_stall_req,
    input  logic [31:0] mem_address,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_en,
    output logic [31:0] mem_rdata,
    output logic        mem_stall_req,
    output logic        time_int,
    output logic        clear_mip,
    output logic [19:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [3:0]  sram_be_n
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;
    typedef enum logic {OWN_INST, OWN_DATA} owner_e;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic        is_write_q, is_write_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [19:0] sram_addr_q, sram_addr_d;
    logic [31:0] sram_wdata_q, sram_wdata_d;
    logic [3:0]  sram_be_n_q, sram_be_n_d;

    logic        data_req;
    logic        timer_hit;
    logic [31:0] timer_rdata;
    logic        unused_addr_bits;

    assign data_req         = mem_load | mem_store;
    assign unused_addr_bits = ^{if_address[31:22], if_address[1:0],
                                mem_address[31:22], mem_address[1:0]};

`ifdef SRAM_ARB_MTIMER_EN
    localparam logic [29:0] MTIME_LO_W    = MTIME_ADDR[31:2];
    localparam logic [29:0] MTIME_HI_W    = MTIME_ADDR[31:2] + 30'd1;
    localparam logic [29:0] MTIMECMP_LO_W = MTIMECMP_ADDR[31:2];
    localparam logic [29:0] MTIMECMP_HI_W = MTIMECMP_ADDR[31:2] + 30'd1;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        time_int_q, time_int_d;
    logic        clear_mip_q, clear_mip_d;
    logic        hit_mtime_lo, hit_mtime_hi, hit_cmp_lo, hit_cmp_hi;
    logic        timer_wr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return res;
    endfunction

    assign hit_mtime_lo = (mem_address[31:2] == MTIME_LO_W);
    assign hit_mtime_hi = (mem_address[31:2] == MTIME_HI_W);
    assign hit_cmp_lo   = (mem_address[31:2] == MTIMECMP_LO_W);
    assign hit_cmp_hi   = (mem_address[31:2] == MTIMECMP_HI_W);
    assign timer_hit    = hit_mtime_lo | hit_mtime_hi | hit_cmp_lo | hit_cmp_hi;
    assign timer_wr     = (state_q == S_IDLE) & mem_store & timer_hit;

    always_comb begin
        timer_rdata = '0;
        if (hit_mtime_lo)      timer_rdata = mtime_q[31:0];
        else if (hit_mtime_hi) timer_rdata = mtime_q[63:32];
        else if (hit_cmp_lo)   timer_rdata = mtimecmp_q[31:0];
        else if (hit_cmp_hi)   timer_rdata = mtimecmp_q[63:32];
    end

    // Compare on the next-state values so time_int_q tracks mtime_q >= mtimecmp_q in the same cycle.
    always_comb begin
        mtime_d     = mtime_q + 64'd1;
        mtimecmp_d  = mtimecmp_q;
        clear_mip_d = 1'b0;
        if (timer_wr) begin
            if (hit_mtime_lo) begin
                mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], mem_wdata, mem_byte_en)};
            end else if (hit_mtime_hi) begin
                mtime_d = {merge_bytes(mtime_q[63:32], mem_wdata, mem_byte_en), mtime_q[31:0]};
            end else if (hit_cmp_lo) begin
                mtimecmp_d  = {mtimecmp_q[63:32], merge_bytes(mtimecmp_q[31:0], mem_wdata, mem_byte_en)};
                clear_mip_d = 1'b1;
            end else begin
                mtimecmp_d  = {merge_bytes(mtimecmp_q[63:32], mem_wdata, mem_byte_en), mtimecmp_q[31:0]};
                clear_mip_d = 1'b1;
            end
        end
        time_int_d = (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            time_int_q  <= 1'b0;
            clear_mip_q <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            time_int_q  <= time_int_d;
            clear_mip_q <= clear_mip_d;
        end
    end

    assign time_int  = time_int_q;
    assign clear_mip = clear_mip_q;
`else
    assign timer_hit   = 1'b0;
    assign timer_rdata = '0;
    assign time_int    = 1'b0;
    assign clear_mip   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_INST;
            is_write_q   <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_be_n_q  <= '1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            is_write_q   <= is_write_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_be_n_q  <= sram_be_n_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        is_write_d   = is_write_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_be_n_d  = sram_be_n_q;
        unique case (state_q)
            S_IDLE: begin
                if (data_req) begin
                    owner_d    = OWN_DATA;
                    is_write_d = mem_store;
                    if (timer_hit) begin
                        // Timer registers answer immediately; the SRAM is never strobed.
                        rdata_d = timer_rdata;
                        state_d = S_DONE;
                    end else begin
                        sram_addr_d  = mem_address[21:2];
                        sram_wdata_d = mem_wdata;
                        sram_be_n_d  = mem_store ? ~mem_byte_en : 4'b0000;
                        cnt_d        = '0;
                        state_d      = S_ACCESS;
                    end
                end else if (if_load) begin
                    owner_d      = OWN_INST;
                    is_write_d   = 1'b0;
                    sram_addr_d  = if_address[21:2];
                    sram_wdata_d = '0;
                    sram_be_n_d  = 4'b0000;
                    cnt_d        = '0;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    rdata_d = sram_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sram_ce_n      = 1'b1;
        sram_oe_n      = 1'b1;
        sram_we_n      = 1'b1;
        mem_stall_req  = data_req & !(state_q == S_DONE && owner_q == OWN_DATA);
        ibus_stall_req = if_load  & !(state_q == S_DONE && owner_q == OWN_INST);
        if (state_q == S_ACCESS) begin
            sram_ce_n = 1'b0;
            if (is_write_q) sram_we_n = !(cnt_q < LAST_CNT);
            else            sram_oe_n = 1'b0;
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_be_n  = sram_be_n_q;
    assign if_rdata   = rdata_q;
    assign mem_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with a behavioural async SRAM; timer checks when SRAM_ARB_MTIMER_EN is set.
module tb_sram_bus_arbiter;

    localparam int KFETCH = 0;
    localparam int KLOAD  = 1;
    localparam int KSTORE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_address, mem_address, mem_wdata;
    logic        if_load, mem_load, mem_store;
    logic [3:0]  mem_byte_en;
    logic [31:0] if_rdata, mem_rdata;
    logic        ibus_stall_req, mem_stall_req, time_int, clear_mip;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    logic [31:0] sram_mem [0:1023];

    int checks = 0;
    int errors = 0;

    sram_bus_arbiter #(.WAIT_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .if_address(if_address), .if_load(if_load), .if_rdata(if_rdata),
        .ibus_stall_req(ibus_stall_req),
        .mem_address(mem_address), .mem_load(mem_load), .mem_store(mem_store),
        .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata),
        .mem_stall_req(mem_stall_req), .time_int(time_int), .clear_mip(clear_mip),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n)
    );

    always #5 clk = ~clk;

    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) sram_mem[sram_addr[9:0]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] rdata, output int stalls,
                           output logic [19:0] s_addr, output logic [31:0] s_wdata,
                           output logic [3:0] s_be_n, output int ce_cnt, output int we_cnt,
                           output int oe_cnt);
        logic stall;
        @(negedge clk);
        if_load     = (kind == KFETCH);
        mem_load    = (kind == KLOAD);
        mem_store   = (kind == KSTORE);
        if_address  = addr;
        mem_address = addr;
        mem_wdata   = wdata;
        mem_byte_en = be;
        stalls = 0; ce_cnt = 0; we_cnt = 0; oe_cnt = 0;
        s_addr = '0; s_wdata = '0; s_be_n = '1;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (!sram_ce_n) begin
                ce_cnt++;
                s_addr = sram_addr; s_wdata = sram_wdata; s_be_n = sram_be_n;
                if (!sram_we_n) we_cnt++;
                if (!sram_oe_n) oe_cnt++;
            end
            stall = (kind == KFETCH) ? ibus_stall_req : mem_stall_req;
            if (!stall) break;
            stalls++;
            @(negedge clk); #1;
        end
        rdata = (kind == KFETCH) ? if_rdata : mem_rdata;
        if_load = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
    endtask

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        int          exp_stalls;
        logic [19:0] exp_sram_addr;
        logic [3:0]  exp_be_n;
        int          exp_we;
        int          exp_oe;
    } vec_t;

    vec_t        vecs [0:15];
    int          n_vec;
    logic [31:0] rd;
    int          st, cc, wc, oc;
    logic [19:0] sa;
    logic [31:0] sw;
    logic [3:0]  sb;

    initial begin
        n_vec = 0;
        vecs[n_vec++] = '{KFETCH, 32'h40,        32'h0,        4'h0, 32'hDEADBEEF, 4, 20'h00010, 4'b0000, 0, 3};
        vecs[n_vec++] = '{KLOAD,  32'h40,        32'h0,        4'h0, 32'hDEADBEEF, 4, 20'h00010, 4'b0000, 0, 3};
        vecs[n_vec++] = '{KLOAD,  32'h100,       32'h0,        4'h0, 32'h11223344, 4, 20'h00040, 4'b0000, 0, 3};
        vecs[n_vec++] = '{KSTORE, 32'h100,       32'h0000AB00, 4'b0010, 32'h0,     4, 20'h00040, 4'b1101, 2, 0};
        vecs[n_vec++] = '{KLOAD,  32'h100,       32'h0,        4'h0, 32'h1122AB44, 4, 20'h00040, 4'b0000, 0, 3};
        vecs[n_vec++] = '{KFETCH, 32'h100,       32'h0,        4'h0, 32'h1122AB44, 4, 20'h00040, 4'b0000, 0, 3};
        vecs[n_vec++] = '{KSTORE, 32'h80,        32'hA5A5A5A5, 4'hF, 32'h0,        4, 20'h00020, 4'b0000, 2, 0};
        vecs[n_vec++] = '{KLOAD,  32'h80,        32'h0,        4'h0, 32'hA5A5A5A5, 4, 20'h00020, 4'b0000, 0, 3};
        vecs[n_vec++] = '{KSTORE, 32'h80,        32'h12345678, 4'b1001, 32'h0,     4, 20'h00020, 4'b0110, 2, 0};
        vecs[n_vec++] = '{KFETCH, 32'h80,        32'h0,        4'h0, 32'h12A5A578, 4, 20'h00020, 4'b0000, 0, 3};
        vecs[n_vec++] = '{KLOAD,  32'h0040_0040, 32'h0,        4'h0, 32'hDEADBEEF, 4, 20'h00010, 4'b0000, 0, 3};
        vecs[n_vec++] = '{KFETCH, 32'h0200_4000, 32'h0,        4'h0, 32'hC0FFEE00, 4, 20'h01000, 4'b0000, 0, 3};
`ifndef SRAM_ARB_MTIMER_EN
        vecs[n_vec++] = '{KLOAD,  32'h0200_4000, 32'h0,        4'h0, 32'hC0FFEE00, 4, 20'h01000, 4'b0000, 0, 3};
`endif

        for (int i = 0; i < 1024; i++) sram_mem[i] = 32'h0;
        sram_mem[10'h000] = 32'hC0FFEE00;
        sram_mem[10'h010] = 32'hDEADBEEF;
        sram_mem[10'h040] = 32'h11223344;

        rst = 1'b0;
        if_load = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
        if_address = '0; mem_address = '0; mem_wdata = '0; mem_byte_en = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ce_n", sram_ce_n, 1'b1);
        chk("rst_oe_n", sram_oe_n, 1'b1);
        chk("rst_we_n", sram_we_n, 1'b1);
        chk("rst_be_n", sram_be_n, 4'hF);
        chk("rst_addr", sram_addr, 20'h0);
        chk("rst_wdata", sram_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_time_int", time_int, 1'b0);
        chk("rst_clear_mip", clear_mip, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_ibus_stall", ibus_stall_req, 1'b0);
        chk("idle_mem_stall", mem_stall_req, 1'b0);

        for (int v = 0; v < n_vec; v++) begin
            run_txn(vecs[v].kind, vecs[v].addr, vecs[v].wdata, vecs[v].be, rd, st, sa, sw, sb, cc, wc, oc);
            chk($sformatf("v%0d_stalls", v), 64'(st), 64'(vecs[v].exp_stalls));
            chk($sformatf("v%0d_ce_cycles", v), 64'(cc), 64'd3);
            chk($sformatf("v%0d_sram_addr", v), sa, vecs[v].exp_sram_addr);
            chk($sformatf("v%0d_be_n", v), sb, vecs[v].exp_be_n);
            chk($sformatf("v%0d_we_cycles", v), 64'(wc), 64'(vecs[v].exp_we));
            chk($sformatf("v%0d_oe_cycles", v), 64'(oc), 64'(vecs[v].exp_oe));
            if (vecs[v].kind == KSTORE) chk($sformatf("v%0d_wdata", v), sw, vecs[v].wdata);
            else                         chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
            chk($sformatf("v%0d_done_strobes", v), {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        end

        // Data and fetch requested together: data finishes at cycle 4, fetch at cycle 9.
        begin
            int mem_done, if_done;
            logic [31:0] mdata, idata;
            mem_done = -1; if_done = -1; mdata = '0; idata = '0;
            @(negedge clk);
            if_load = 1'b1; if_address = 32'h40;
            mem_load = 1'b1; mem_address = 32'h100;
            #1;
            for (int c = 0; c < 30; c++) begin
                if (mem_done < 0 && !mem_stall_req) begin
                    mem_done = c; mdata = mem_rdata; mem_load = 1'b0;
                end
                if (if_done < 0 && !ibus_stall_req) begin
                    if_done = c; idata = if_rdata; if_load = 1'b0;
                end
                if (mem_done >= 0 && if_done >= 0) break;
                @(negedge clk); #1;
            end
            mem_load = 1'b0; if_load = 1'b0;
            chk("arb_mem_done_cycle", 64'(mem_done), 64'd4);
            chk("arb_if_done_cycle", 64'(if_done), 64'd9);
            chk("arb_mem_rdata", mdata, 32'h1122AB44);
            chk("arb_if_rdata", idata, 32'hDEADBEEF);
        end

        // Reset asserted while a store is driving sram_we_n low.
        @(negedge clk);
        mem_store = 1'b1; mem_address = 32'h200; mem_wdata = 32'h55AA55AA; mem_byte_en = 4'hF;
        @(negedge clk); #1;
        chk("midwr_we_low", sram_we_n, 1'b0);
        rst = 1'b0;
        if_load = 1'b1; if_address = 32'h40;
        #1;
        chk("midwr_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        chk("midwr_be_n", sram_be_n, 4'hF);
        chk("midwr_addr", sram_addr, 20'h0);
        chk("midwr_wdata", sram_wdata, 32'h0);
        chk("midwr_rdata", mem_rdata, 32'h0);
        chk("midwr_mem_stall", mem_stall_req, 1'b1);
        chk("midwr_ibus_stall", ibus_stall_req, 1'b1);
        mem_store = 1'b0; if_load = 1'b0;
        #1;
        chk("midwr_stalls_drop", {mem_stall_req, ibus_stall_req}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        run_txn(KFETCH, 32'h40, 32'h0, 4'h0, rd, st, sa, sw, sb, cc, wc, oc);
        chk("post_rst_stalls", 64'(st), 64'd4);
        chk("post_rst_rdata", rd, 32'hDEADBEEF);

`ifdef SRAM_ARB_MTIMER_EN
        run_txn(KSTORE, 32'h0200_BFF8, 32'd1000, 4'hF, rd, st, sa, sw, sb, cc, wc, oc);
        chk("tmr_st_mtime_stalls", 64'(st), 64'd1);
        chk("tmr_st_mtime_ce", 64'(cc), 64'd0);
        chk("tmr_st_mtime_clear_mip", clear_mip, 1'b0);
        run_txn(KLOAD, 32'h0200_BFF8, 32'h0, 4'h0, rd, st, sa, sw, sb, cc, wc, oc);
        chk("tmr_ld_mtime_lo", rd, 32'd1001);
        chk("tmr_ld_mtime_stalls", 64'(st), 64'd1);
        run_txn(KLOAD, 32'h0200_BFFC, 32'h0, 4'h0, rd, st, sa, sw, sb, cc, wc, oc);
        chk("tmr_ld_mtime_hi", rd, 32'd0);
        chk("tmr_pre_time_int", time_int, 1'b0);

        run_txn(KSTORE, 32'h0200_4000, 32'd50, 4'hF, rd, st, sa, sw, sb, cc, wc, oc);
        chk("tmr_cmp_lo_clear_mip", clear_mip, 1'b1);
        @(negedge clk); #1;
        chk("tmr_cmp_lo_clear_mip_end", clear_mip, 1'b0);
        run_txn(KSTORE, 32'h0200_4004, 32'd0, 4'hF, rd, st, sa, sw, sb, cc, wc, oc);
        chk("tmr_cmp_hi_clear_mip", clear_mip, 1'b1);
        chk("tmr_cmp_hi_time_int", time_int, 1'b1);
        @(negedge clk); #1;
        chk("tmr_cmp_hi_clear_mip_end", clear_mip, 1'b0);

        // mtime is 10 in the DONE cycle of this store, so it reaches 50 forty cycles later.
        run_txn(KSTORE, 32'h0200_BFF8, 32'd10, 4'hF, rd, st, sa, sw, sb, cc, wc, oc);
        chk("tmr_mtime10_time_int", time_int, 1'b0);
        begin
            int rise;
            rise = -1;
            for (int k = 1; k < 100; k++) begin
                @(negedge clk); #1;
                if (time_int) begin
                    rise = k;
                    break;
                end
            end
            chk("tmr_time_int_rise", 64'(rise), 64'd40);
        end

        run_txn(KLOAD, 32'h0200_4000, 32'h0, 4'h0, rd, st, sa, sw, sb, cc, wc, oc);
        chk("tmr_ld_cmp_lo", rd, 32'd50);
        chk("tmr_ld_cmp_stalls", 64'(st), 64'd1);
        chk("tmr_ld_cmp_ce", 64'(cc), 64'd0);
        run_txn(KSTORE, 32'h0200_4000, 32'h0000_1200, 4'b0010, rd, st, sa, sw, sb, cc, wc, oc);
        chk("tmr_cmp_byte_clear_mip", clear_mip, 1'b1);
        run_txn(KLOAD, 32'h0200_4000, 32'h0, 4'h0, rd, st, sa, sw, sb, cc, wc, oc);
        chk("tmr_cmp_byte_rdata", rd, 32'h0000_1232);
        chk("tmr_cmp_byte_time_int", time_int, 1'b0);
`else
        repeat (20) @(negedge clk);
        #1;
        chk("notmr_time_int", time_int, 1'b0);
        chk("notmr_clear_mip", clear_mip, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
